// File: rtl/sirc_pkg.sv
// Shared types and constants for the SIRC PUF sequencer.
// State encoding, handshake address widths and the timeout fill byte.
package sirc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARAM,
        S_LOAD,
        S_TRIG,
        S_WAIT,
        S_WRITE,
        S_STATUS,
        S_CLEAR
    } state_t;

    localparam int REG_ADDR_W    = 8;
    localparam int INMEM_AW_DEF  = 17;
    localparam int OUTMEM_AW_DEF = 13;

    localparam logic [7:0] TMO_FILL = 8'hFF;

endpackage

// File: rtl/sirc_puf_sequencer_if.sv
// SIRC host-side bundle: run register, param file, input and output memory.
// master = sequencer, slave = SIRC host.
interface sirc_puf_sequencer_if #(
    parameter int INMEM_ADDRESS_WIDTH  = sirc_pkg::INMEM_AW_DEF,
    parameter int OUTMEM_ADDRESS_WIDTH = sirc_pkg::OUTMEM_AW_DEF
);

    logic                            userRunValue;
    logic                            userRunClear;

    logic                            register32CmdReq;
    logic                            register32CmdAck;
    logic [sirc_pkg::REG_ADDR_W-1:0] register32Address;
    logic                            register32ReadDataValid;
    logic [31:0]                     register32ReadData;
    logic                            register32WriteEn;
    logic [31:0]                     register32WriteData;

    logic                            inputMemoryReadReq;
    logic                            inputMemoryReadAck;
    logic [INMEM_ADDRESS_WIDTH-1:0]  inputMemoryReadAdd;
    logic                            inputMemoryReadDataValid;
    logic [7:0]                      inputMemoryReadData;

    logic                            outputMemoryWriteReq;
    logic                            outputMemoryWriteAck;
    logic [OUTMEM_ADDRESS_WIDTH-1:0] outputMemoryWriteAdd;
    logic [7:0]                      outputMemoryWriteData;
    logic                            outputMemoryWriteByteMask;

    modport master (
        input  userRunValue,
        output userRunClear,
        output register32CmdReq,
        input  register32CmdAck,
        output register32Address,
        input  register32ReadDataValid,
        input  register32ReadData,
        output register32WriteEn,
        output register32WriteData,
        output inputMemoryReadReq,
        input  inputMemoryReadAck,
        output inputMemoryReadAdd,
        input  inputMemoryReadDataValid,
        input  inputMemoryReadData,
        output outputMemoryWriteReq,
        input  outputMemoryWriteAck,
        output outputMemoryWriteAdd,
        output outputMemoryWriteData,
        output outputMemoryWriteByteMask
    );

    modport slave (
        output userRunValue,
        input  userRunClear,
        input  register32CmdReq,
        output register32CmdAck,
        input  register32Address,
        output register32ReadDataValid,
        output register32ReadData,
        input  register32WriteEn,
        input  register32WriteData,
        input  inputMemoryReadReq,
        output inputMemoryReadAck,
        input  inputMemoryReadAdd,
        output inputMemoryReadDataValid,
        output inputMemoryReadData,
        input  outputMemoryWriteReq,
        output outputMemoryWriteAck,
        input  outputMemoryWriteAdd,
        input  outputMemoryWriteData,
        input  outputMemoryWriteByteMask
    );

endinterface

// File: rtl/sirc_req_ack.sv
// Generic req/ack issue unit: latches an address on start, holds req
// until req&&ack, then drops req on the following cycle.
module sirc_req_ack #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          ack,
    output logic          req,
    output logic [AW-1:0] addr,
    output logic          fire
);

    assign fire = req & ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req  <= 1'b0;
            addr <= '0;
        end else if (fire) begin
            req <= 1'b0;
        end else if (start && !req) begin
            req  <= 1'b1;
            addr <= start_addr;
        end
    end

endmodule

// File: rtl/sirc_puf_sequencer.sv
// SIRC host sequencer for PUF runs: params, PDL config load, triggered
// runs with timeout, response bytes and a timeout-count status byte out.
module sirc_puf_sequencer
    import sirc_pkg::*;
#(
    parameter int CHAL_BYTES           = 16,
    parameter int RESP_BYTES           = 2,
    parameter int N_PARAMS             = 2,
    parameter int INMEM_ADDRESS_WIDTH  = INMEM_AW_DEF,
    parameter int OUTMEM_ADDRESS_WIDTH = OUTMEM_AW_DEF,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sirc_puf_sequencer_if.master    sirc,
    output logic [CHAL_BYTES*8-1:0] puf_pdl_config,
    output logic [31:0]             puf_challenge,
    output logic                    puf_trigger,
    input  logic                    puf_done,
    input  logic [RESP_BYTES*8-1:0] puf_response,
    output logic                    busy
);

    localparam int IAW = INMEM_ADDRESS_WIDTH;
    localparam int OAW = OUTMEM_ADDRESS_WIDTH;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state, state_n;
    logic [7:0]              cnt, run, runs, tmo;
    logic [31:0]             base;
    logic [TW-1:0]           tmr;
    logic [RESP_BYTES*8-1:0] resp;
    logic [OAW-1:0]          wptr;
    logic [7:0]              wdata, wr_byte;
    logic                    rd_wait, rd_vld, rd_hit;
    logic                    reg_go, in_go, out_go;
    logic                    reg_req, in_req, out_req;
    logic                    reg_fire, in_fire, out_fire;
    logic [REG_ADDR_W-1:0]   reg_addr;
    logic [IAW-1:0]          in_addr;
    logic [OAW-1:0]          out_addr;

    sirc_req_ack #(.AW(REG_ADDR_W)) u_reg (
        .clk(clk), .reset_n(reset_n), .start(reg_go),
        .start_addr(cnt), .ack(sirc.register32CmdAck),
        .req(reg_req), .addr(reg_addr), .fire(reg_fire)
    );

    sirc_req_ack #(.AW(IAW)) u_in (
        .clk(clk), .reset_n(reset_n), .start(in_go),
        .start_addr(IAW'(cnt)), .ack(sirc.inputMemoryReadAck),
        .req(in_req), .addr(in_addr), .fire(in_fire)
    );

    sirc_req_ack #(.AW(OAW)) u_out (
        .clk(clk), .reset_n(reset_n), .start(out_go),
        .start_addr(wptr), .ack(sirc.outputMemoryWriteAck),
        .req(out_req), .addr(out_addr), .fire(out_fire)
    );

    assign sirc.register32CmdReq          = reg_req;
    assign sirc.register32Address         = reg_addr;
    assign sirc.register32WriteEn         = 1'b0;
    assign sirc.register32WriteData       = 32'h0;
    assign sirc.inputMemoryReadReq        = in_req;
    assign sirc.inputMemoryReadAdd        = in_addr;
    assign sirc.outputMemoryWriteReq      = out_req;
    assign sirc.outputMemoryWriteAdd      = out_addr;
    assign sirc.outputMemoryWriteData     = wdata;
    assign sirc.outputMemoryWriteByteMask = 1'b1;
    assign sirc.userRunClear              = (state == S_CLEAR);
    assign busy                           = (state != S_IDLE);

    // Read data may arrive on the ack cycle or any later cycle.
    assign rd_vld = (state == S_PARAM) ? sirc.register32ReadDataValid
                  : (state == S_LOAD) & sirc.inputMemoryReadDataValid;
    assign rd_hit = (rd_wait | reg_fire | in_fire) & rd_vld;

    always_comb begin
        state_n = state;
        reg_go  = 1'b0;
        in_go   = 1'b0;
        out_go  = 1'b0;
        wr_byte = 8'h00;
        case (state)
            S_IDLE:
                if (sirc.userRunValue && !sirc.userRunClear)
                    state_n = S_PARAM;
            S_PARAM: begin
                reg_go = !reg_req && !rd_wait;
                if (rd_hit && cnt == 8'(N_PARAMS - 1))
                    state_n = S_LOAD;
            end
            S_LOAD: begin
                in_go = !in_req && !rd_wait;
                if (rd_hit && cnt == 8'(CHAL_BYTES - 1))
                    state_n = S_TRIG;
            end
            S_TRIG:
                state_n = S_WAIT;
            S_WAIT:
                if (puf_done || tmr == TW'(TIMEOUT_CYCLES - 1))
                    state_n = S_WRITE;
            S_WRITE: begin
                out_go = !out_req;
                for (int j = 0; j < RESP_BYTES; j++)
                    if (cnt == 8'(j))
                        wr_byte = resp[8*(RESP_BYTES-1-j) +: 8];
                if (out_fire && cnt == 8'(RESP_BYTES - 1))
                    state_n = (run == runs - 8'd1) ? S_STATUS : S_TRIG;
            end
            S_STATUS: begin
                out_go  = !out_req;
                wr_byte = tmo;
                if (out_fire)
                    state_n = S_CLEAR;
            end
            S_CLEAR:
                if (!sirc.userRunValue)
                    state_n = S_IDLE;
            default:
                state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            run            <= '0;
            runs           <= '0;
            tmo            <= '0;
            base           <= '0;
            tmr            <= '0;
            resp           <= '0;
            wptr           <= '0;
            wdata          <= '0;
            rd_wait        <= 1'b0;
            puf_trigger    <= 1'b0;
            puf_challenge  <= '0;
            puf_pdl_config <= '0;
        end else begin
            rd_wait     <= (rd_wait | reg_fire | in_fire) & ~rd_vld;
            puf_trigger <= (state == S_TRIG);
            if (out_go)
                wdata <= wr_byte;
            case (state)
                S_IDLE: begin
                    cnt  <= '0;
                    run  <= '0;
                    tmo  <= '0;
                    wptr <= '0;
                end
                S_PARAM:
                    if (rd_hit) begin
                        if (cnt == 8'd0)
                            runs <= (sirc.register32ReadData[7:0] == 8'd0)
                                  ? 8'd1 : sirc.register32ReadData[7:0];
                        if (cnt == 8'd1)
                            base <= sirc.register32ReadData;
                        cnt <= (cnt == 8'(N_PARAMS - 1)) ? 8'd0 : cnt + 8'd1;
                    end
                S_LOAD:
                    if (rd_hit) begin
                        for (int k = 0; k < CHAL_BYTES; k++)
                            if (cnt == 8'(k))
                                puf_pdl_config[8*k +: 8] <= sirc.inputMemoryReadData;
                        cnt <= (cnt == 8'(CHAL_BYTES - 1)) ? 8'd0 : cnt + 8'd1;
                    end
                S_TRIG: begin
                    puf_challenge <= base + {24'h0, run};
                    tmr           <= '0;
                end
                S_WAIT:
                    if (puf_done) begin
                        resp <= puf_response;
                    end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                        resp <= {RESP_BYTES{TMO_FILL}};
                        if (tmo != 8'hFF)
                            tmo <= tmo + 8'd1;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                S_WRITE:
                    if (out_fire) begin
                        wptr <= wptr + OAW'(1);
                        if (cnt == 8'(RESP_BYTES - 1)) begin
                            cnt <= '0;
                            run <= run + 8'd1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sirc_puf_sequencer.sv
// Bench for sirc_puf_sequencer: SIRC host and PUF models on the
// falling edge, with expected writes and challenges queued per run.
`timescale 1ns/1ps
module tb_sirc_puf_sequencer;

    localparam int CB  = 16;
    localparam int RB  = 2;
    localparam int NP  = 2;
    localparam int IAW = 17;
    localparam int OAW = 13;
    localparam int TMO = 1024;

    typedef struct {
        logic [31:0] reg0;
        logic [31:0] reg1;
        bit          never;
        logic [15:0] resp;
        int          lat;
        bit          rnd;
        logic [7:0]  ofs;
        bit          drop;
    } vec_t;

    typedef struct packed {
        logic [OAW-1:0] a;
        logic [7:0]     d;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sirc_puf_sequencer_if #(
        .INMEM_ADDRESS_WIDTH(IAW),
        .OUTMEM_ADDRESS_WIDTH(OAW)
    ) sif ();

    logic [CB*8-1:0] puf_pdl_config;
    logic [31:0]     puf_challenge;
    logic            puf_trigger;
    logic            puf_done = 1'b0;
    logic [RB*8-1:0] puf_response = '0;
    logic            busy;

    sirc_puf_sequencer #(
        .CHAL_BYTES(CB), .RESP_BYTES(RB), .N_PARAMS(NP),
        .INMEM_ADDRESS_WIDTH(IAW), .OUTMEM_ADDRESS_WIDTH(OAW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sirc(sif.master),
        .puf_pdl_config(puf_pdl_config),
        .puf_challenge(puf_challenge),
        .puf_trigger(puf_trigger),
        .puf_done(puf_done),
        .puf_response(puf_response),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [127:0] act,
                                input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    logic [31:0] regs [NP];
    logic [7:0]  inmem [CB];
    bit          rnd = 1'b0;
    bit          cur_never = 1'b0;
    logic [15:0] cur_resp = '0;
    int          cur_lat = 0;
    wr_t         exp_wr [$];
    logic [31:0] exp_ch [$];
    int          n_trig = 0;
    int          cyc = 0;
    int          t_trig = 0;

    always @(negedge clk) cyc++;

    // Parameter-file port
    bit         r_busy = 0, r_vp = 0;
    int         r_dly = 0;
    logic [7:0] r_a = '0;
    always @(negedge clk) begin
        sif.register32CmdAck = 1'b0;
        sif.register32ReadDataValid = 1'b0;
        if (!reset_n) begin
            r_busy = 0;
            r_vp = 0;
        end else begin
            if (r_vp) begin
                sif.register32ReadDataValid = 1'b1;
                sif.register32ReadData = (int'(r_a) < NP) ? regs[r_a[0]] : 32'hDEAD_BEEF;
                r_vp = 0;
            end
            if (sif.register32CmdReq) begin
                if (!r_busy) begin
                    r_busy = 1;
                    r_dly = rnd ? int'($urandom_range(0, 5)) : 0;
                end
                if (r_dly == 0) begin
                    sif.register32CmdAck = 1'b1;
                    r_a = sif.register32Address;
                    r_vp = 1;
                    r_busy = 0;
                end else r_dly--;
            end
        end
    end

    // Input memory port
    bit             i_busy = 0, i_vp = 0;
    int             i_dly = 0;
    logic [IAW-1:0] i_a = '0;
    always @(negedge clk) begin
        sif.inputMemoryReadAck = 1'b0;
        sif.inputMemoryReadDataValid = 1'b0;
        if (!reset_n) begin
            i_busy = 0;
            i_vp = 0;
        end else begin
            if (i_vp) begin
                sif.inputMemoryReadDataValid = 1'b1;
                sif.inputMemoryReadData = (int'(i_a) < CB) ? inmem[i_a[3:0]] : 8'hEE;
                i_vp = 0;
            end
            if (sif.inputMemoryReadReq) begin
                if (!i_busy) begin
                    i_busy = 1;
                    i_dly = rnd ? int'($urandom_range(0, 5)) : 0;
                end
                if (i_dly == 0) begin
                    sif.inputMemoryReadAck = 1'b1;
                    i_a = sif.inputMemoryReadAdd;
                    i_vp = 1;
                    i_busy = 0;
                end else i_dly--;
            end
        end
    end

    // Output memory port: each accepted write is checked against the queue
    bit             o_busy = 0;
    int             o_dly = 0;
    logic [OAW-1:0] o_a = '0;
    logic [7:0]     o_d = '0;
    wr_t            o_e;
    always @(negedge clk) begin
        sif.outputMemoryWriteAck = 1'b0;
        if (!reset_n) begin
            o_busy = 0;
        end else if (sif.outputMemoryWriteReq) begin
            if (!o_busy) begin
                o_busy = 1;
                o_a = sif.outputMemoryWriteAdd;
                o_d = sif.outputMemoryWriteData;
                o_dly = rnd ? int'($urandom_range(0, 5)) : 0;
                if (cur_never && t_trig != 0) begin
                    chk("tmo_len", 128'((cyc - t_trig >= TMO) && (cyc - t_trig <= TMO + 3)), 128'(1));
                    t_trig = 0;
                end
            end else begin
                chk("wr_hold", 128'({sif.outputMemoryWriteAdd, sif.outputMemoryWriteData}),
                    128'({o_a, o_d}));
            end
            if (o_dly == 0) begin
                sif.outputMemoryWriteAck = 1'b1;
                o_busy = 0;
                if (exp_wr.size() == 0) begin
                    chk("wr_extra", 128'({o_a, o_d}), 128'(0) - 128'(1));
                end else begin
                    o_e = exp_wr.pop_front();
                    chk("wr_addr", 128'(sif.outputMemoryWriteAdd), 128'(o_e.a));
                    chk("wr_data", 128'(sif.outputMemoryWriteData), 128'(o_e.d));
                end
            end else o_dly--;
        end
    end

    // PUF core model
    bit          p_pend = 0, p_last = 0;
    int          p_cnt = 0;
    logic [15:0] p_resp = '0;
    always @(negedge clk) begin
        puf_done = 1'b0;
        if (!reset_n) begin
            p_pend = 0;
            p_last = 0;
        end else begin
            if (puf_trigger) begin
                chk("trig_pulse", 128'(p_last), 128'(0));
                n_trig++;
                t_trig = cyc;
                if (exp_ch.size() == 0)
                    chk("trig_extra", 128'(puf_challenge), 128'(0) - 128'(1));
                else
                    chk("challenge", 128'(puf_challenge), 128'(exp_ch.pop_front()));
                if (!cur_never) begin
                    p_pend = 1;
                    p_cnt = cur_lat;
                    p_resp = cur_resp ^ puf_challenge[15:0];
                end
            end else if (p_pend) begin
                if (p_cnt == 0) begin
                    puf_done = 1'b1;
                    puf_response = p_resp;
                    p_pend = 0;
                end else p_cnt--;
            end
            p_last = puf_trigger;
        end
    end

    // Build expectations for one vector; returns expected config
    task automatic setup_vec(input vec_t v, output logic [CB*8-1:0] ecfg, output int runs);
        logic [OAW-1:0] a;
        logic [31:0]    ch;
        logic [15:0]    r;
        int             to;
        regs[0] = v.reg0;
        regs[1] = v.reg1;
        rnd = v.rnd;
        cur_never = v.never;
        cur_resp = v.resp;
        cur_lat = v.lat;
        for (int k = 0; k < CB; k++) begin
            inmem[k] = 8'(k) + v.ofs;
            ecfg[8*k +: 8] = 8'(k) + v.ofs;
        end
        runs = (v.reg0[7:0] == 8'd0) ? 1 : int'(v.reg0[7:0]);
        a = '0;
        to = 0;
        for (int i = 0; i < runs; i++) begin
            ch = v.reg1 + 32'(i);
            exp_ch.push_back(ch);
            r = v.never ? 16'hFFFF : (v.resp ^ ch[15:0]);
            if (v.never) to++;
            exp_wr.push_back({a, r[15:8]});
            a = a + OAW'(1);
            exp_wr.push_back({a, r[7:0]});
            a = a + OAW'(1);
        end
        exp_wr.push_back({a, (to > 255) ? 8'hFF : 8'(to)});
    endtask

    task automatic run_vec(input vec_t v);
        logic [CB*8-1:0] ecfg;
        int runs, wd, t0;
        setup_vec(v, ecfg, runs);
        t0 = n_trig;
        @(negedge clk);
        sif.userRunValue = 1'b1;
        wd = 0;
        while (!busy && wd < 20) begin
            @(negedge clk);
            wd++;
        end
        chk("busy_rise", 128'(busy), 128'(1));
        if (v.drop) sif.userRunValue = 1'b0;
        wd = 0;
        while (!sif.userRunClear && wd < 6000) begin
            @(negedge clk);
            wd++;
        end
        chk("clear_seen", 128'(sif.userRunClear), 128'(1));
        chk("pdl_config", 128'(puf_pdl_config), 128'(ecfg));
        chk("wr_left", 128'(exp_wr.size()), 128'(0));
        chk("ch_left", 128'(exp_ch.size()), 128'(0));
        chk("trig_count", 128'(n_trig - t0), 128'(runs));
        if (!v.drop) begin
            repeat (10) @(negedge clk);
            chk("clear_hold", 128'(sif.userRunClear), 128'(1));
            sif.userRunValue = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_clear", 128'(sif.userRunClear), 128'(0));
        repeat (10) @(negedge clk);
        chk("no_restart", 128'(n_trig - t0), 128'(runs));
        exp_wr.delete();
        exp_ch.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_reqs"}, 128'({sif.register32CmdReq, sif.inputMemoryReadReq,
                                  sif.outputMemoryWriteReq, sif.userRunClear, puf_trigger}), 128'(0));
        chk({tag, "_addrs"}, 128'({sif.register32Address, sif.inputMemoryReadAdd,
                                   sif.outputMemoryWriteAdd, sif.outputMemoryWriteData}), 128'(0));
        chk({tag, "_chal"}, 128'(puf_challenge), 128'(0));
        chk({tag, "_cfg"}, 128'(puf_pdl_config), 128'(0));
        chk({tag, "_wen"}, 128'({sif.register32WriteEn, sif.outputMemoryWriteByteMask}), 128'(1));
    endtask

    vec_t vt [5];

    initial begin
        logic [CB*8-1:0] dcfg;
        int              druns, wd, t0;
        vt[0] = '{32'd1, 32'hA5A5_0000, 1'b0, 16'h1234, 20, 1'b0, 8'h00, 1'b0};
        vt[1] = '{32'd3, 32'hFFFF_FFFF, 1'b0, 16'h1234, 5,  1'b0, 8'h40, 1'b0};
        vt[2] = '{32'd2, 32'h0000_1000, 1'b1, 16'h0000, 0,  1'b0, 8'h20, 1'b0};
        vt[3] = '{32'd4, 32'h1234_5678, 1'b0, 16'hC3C3, 3,  1'b1, 8'h80, 1'b1};
        vt[4] = '{32'd0, 32'h0BAD_0000, 1'b0, 16'h5A5A, 7,  1'b1, 8'hF0, 1'b0};

        sif.userRunValue = 1'b0;
        sif.register32CmdAck = 1'b0;
        sif.register32ReadDataValid = 1'b0;
        sif.register32ReadData = '0;
        sif.inputMemoryReadAck = 1'b0;
        sif.inputMemoryReadDataValid = 1'b0;
        sif.inputMemoryReadData = '0;
        sif.outputMemoryWriteAck = 1'b0;

        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Reset asserted during the writes of the second run
        setup_vec('{32'd3, 32'h0000_0100, 1'b0, 16'h7777, 4, 1'b0, 8'h11, 1'b0}, dcfg, druns);
        t0 = n_trig;
        @(negedge clk);
        sif.userRunValue = 1'b1;
        wd = 0;
        while (!(n_trig - t0 == 2 && sif.outputMemoryWriteReq) && wd < 3000) begin
            @(negedge clk);
            wd++;
        end
        chk("mid_write_reached", 128'(n_trig - t0 == 2 && sif.outputMemoryWriteReq), 128'(1));
        reset_n = 1'b0;
        sif.userRunValue = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        exp_wr.delete();
        exp_ch.delete();
        reset_n = 1'b1;
        @(negedge clk);
        run_vec(vt[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
